// File: rtl/instr_fetch_seq.sv
// rtl/instr_fetch_seq.sv - byte-serial instruction fetch sequencer
//
// Fetches four consecutive bytes from a byte-wide instruction memory port and
// drives the write side of the instruction register. The register assembles a
// big-endian word: byte k=0 (address pc) lands in bits 31:24 via IRWrite[0],
// and byte k=3 (address pc+3) lands in bits 7:0 via IRWrite[3].
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, pc           fetch request and instruction byte address
//   busy, done          fetch in progress / one-cycle pulse on completion
//   mem_rd, mem_addr    read request and byte address (pc + k, wraps mod 2^AW)
//   mem_ack, mem_rdata  read data valid strobe and read byte
//   IRWrite             one-hot byte write strobe to the instruction register
//   instr8bit_top       registered byte being written
//   fetch_en            assembled word valid (held high in DONE)
//   fetch_err           memory timeout flag
//
// Optional feature: define FETCH_TIMEOUT_EN to enable the per-byte mem_ack
// timeout and the ERR state. Without it REQ waits indefinitely.

module instr_fetch_seq #(
  parameter int AW          = 8,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [7:0]    mem_rdata,
  output logic [3:0]    IRWrite,
  output logic [7:0]    instr8bit_top,
  output logic          fetch_en,
  output logic          fetch_err
);

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [1:0]    k_q, k_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    byte_q, byte_d;
  logic          done_q, done_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= 2'd0;
      addr_q  <= '0;
      byte_q  <= 8'd0;
      done_q  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    addr_d   = addr_q;
    byte_d   = byte_q;
    busy     = 1'b0;
    mem_rd   = 1'b0;
    IRWrite  = 4'b0000;
    fetch_en = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    fetch_err = 1'b0;
    // Counter only advances while waiting in REQ; every other state rearms it.
    cnt_d     = '0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_REQ;
          k_d     = 2'd0;
          addr_d  = pc;
        end
      end

      S_REQ: begin
        busy   = 1'b1;
        mem_rd = 1'b1;
        if (mem_ack) begin
          byte_d  = mem_rdata;
          state_d = S_WRITE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      S_WRITE: begin
        busy    = 1'b1;
        IRWrite = 4'b0001 << k_q;
        if (k_q == 2'd3) begin
          state_d = S_DONE;
        end else begin
          // Address advances only when re-entering REQ, so it is stable
          // for the whole time mem_rd is high.
          k_d     = k_q + 2'd1;
          addr_d  = addr_q + 1'b1;
          state_d = S_REQ;
        end
      end

      S_DONE: begin
        fetch_en = 1'b1;
        if (start) begin
          state_d = S_REQ;
          k_d     = 2'd0;
          addr_d  = pc;
        end
      end

`ifdef FETCH_TIMEOUT_EN
      S_ERR: begin
        fetch_err = 1'b1;
        if (start) begin
          state_d = S_REQ;
          k_d     = 2'd0;
          addr_d  = pc;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase

    // Pulse only on the transition into DONE, not while it is held.
    done_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

`ifndef FETCH_TIMEOUT_EN
  // No timeout logic: the flag is constant low for any legal TIMEOUT_CYC.
  assign fetch_err = (TIMEOUT_CYC < 0);
`endif

  assign done          = done_q;
  assign mem_addr      = addr_q;
  assign instr8bit_top = byte_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// tb/tb_instr_fetch_seq.sv - self-checking bench for instr_fetch_seq

module tb_instr_fetch_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] pc = 8'd0;
  logic       busy, done, mem_rd, mem_ack, fetch_en, fetch_err;
  logic [7:0] mem_addr, mem_rdata, instr8bit_top;
  logic [3:0] IRWrite;

  instr_fetch_seq #(.AW(8), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pc(pc),
    .busy(busy), .done(done), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .IRWrite(IRWrite),
    .instr8bit_top(instr8bit_top), .fetch_en(fetch_en), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          wcnt = 0;
  int          wait_cycles = 0;
  bit          ack_en = 1'b1;
  logic [7:0]  mem [256];
  logic [7:0]  exp_pc = 8'd0;
  int          byte_idx = 0;
  logic [31:0] ir = 32'd0;
  logic [7:0]  mon_addr;
  logic [11:0] sb_e;
  logic [11:0] sb_q [$];

  // Memory model: ack after wait_cycles cycles of mem_rd
  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = mem_rd && ack_en && (wcnt >= wait_cycles);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 wcnt <= 0;
    else if (mem_rd && !mem_ack) wcnt <= wcnt + 1;
    else                        wcnt <= 0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: address checks, scoreboard push on read, pop on IRWrite
  always @(negedge clk) begin
    if (mem_rd === 1'b1) begin
      mon_addr = exp_pc + byte_idx[7:0];
      check("mem_addr", {24'd0, mem_addr}, {24'd0, mon_addr});
      if (mem_ack === 1'b1) begin
        sb_q.push_back({4'b0001 << byte_idx[1:0], mem[mon_addr]});
        byte_idx++;
      end
    end
    if (IRWrite !== 4'b0000) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", {28'd0, IRWrite}, 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        check("IRWrite", {28'd0, IRWrite}, {28'd0, sb_e[11:8]});
        check("instr8bit_top", {24'd0, instr8bit_top}, {24'd0, sb_e[7:0]});
      end
      check("IRWrite_with_fetch_en", {31'd0, fetch_en}, 32'd0);
      for (int i = 0; i < 4; i++)
        if (IRWrite[i]) ir[31-8*i -: 8] = instr8bit_top;
    end
  end

  task automatic do_fetch(input logic [7:0] p, input int w, input int poke);
    int          t0;
    int          n;
    logic [7:0]  a1, a2, a3;
    logic [31:0] exp_ir;
    a1 = p + 8'd1; a2 = p + 8'd2; a3 = p + 8'd3;
    exp_ir = {mem[p], mem[a1], mem[a2], mem[a3]};
    wait_cycles = w;
    @(negedge clk);
    pc = p; start = 1'b1; exp_pc = p; byte_idx = 0; ir = 32'd0; t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    check("busy_c1", {31'd0, busy}, 32'd1);
    check("mem_rd_c1", {31'd0, mem_rd}, 32'd1);
    check("fetch_en_c1", {31'd0, fetch_en}, 32'd0);
    check("fetch_err_c1", {31'd0, fetch_err}, 32'd0);
    n = 1;
    while (done !== 1'b1 && n < 300) begin
      if (poke >= 0 && IRWrite === (4'b0001 << poke)) begin
        start = 1'b1; pc = ~p;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("done_cycle", cyc - t0, 1 + 4 * (w + 2));
    check("fetch_en_done", {31'd0, fetch_en}, 32'd1);
    check("busy_done", {31'd0, busy}, 32'd0);
    check("ir_word", ir, exp_ir);
    @(negedge clk);
    check("done_pulse_end", {31'd0, done}, 32'd0);
    check("fetch_en_held", {31'd0, fetch_en}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t0;
    for (int a = 0; a < 256; a++) mem[a] = 8'(a * 7 + 3);
    mem[8'h10] = 8'h8C; mem[8'h11] = 8'h21; mem[8'h12] = 8'h00; mem[8'h13] = 8'h04;

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_IRWrite", {28'd0, IRWrite}, 32'd0);
    check("rst_instr8bit_top", {24'd0, instr8bit_top}, 32'd0);
    check("rst_fetch_en", {31'd0, fetch_en}, 32'd0);
    check("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    do_fetch(8'h10, 0, -1);
    check("ir_8C210004", ir, 32'h8C210004);
    do_fetch(8'h10, 3, -1);
    do_fetch(8'hFE, 0, -1);
    do_fetch(8'h30, 0, 1);
    do_fetch(8'h20, 0, -1);

    // Reset during WRITE of byte 2
    wait_cycles = 0;
    @(negedge clk);
    pc = 8'h40; start = 1'b1; exp_pc = 8'h40; byte_idx = 0; ir = 32'd0;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (IRWrite !== 4'b0100 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_write2", {28'd0, IRWrite}, 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_IRWrite", {28'd0, IRWrite}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("mid_rst_fetch_en", {31'd0, fetch_en}, 32'd0);
    check("mid_rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    check("mid_rst_instr8bit_top", {24'd0, instr8bit_top}, 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    do_fetch(8'h40, 1, -1);

`ifdef FETCH_TIMEOUT_EN
    ack_en = 1'b0;
    @(negedge clk);
    pc = 8'h50; start = 1'b1; exp_pc = 8'h50; byte_idx = 0; ir = 32'd0; t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (fetch_err !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("err_cycle", cyc - t0, 16);
    check("err_busy", {31'd0, busy}, 32'd0);
    check("err_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("err_fetch_en", {31'd0, fetch_en}, 32'd0);
    check("err_no_bytes", byte_idx, 0);
    ack_en = 1'b1;
    do_fetch(8'h50, 0, -1);
`else
    t0 = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
